adder_result_checker: RTL and testbench
=======================================

// Module: adder_result_checker
// PURPOSE
//  Synthesizable response checker for the registered n_bit_adder. Sits on the same clk/rst as the
//  adder and taps its operands (a, b, cin, en) and its results (s, c). Keeps a shadow model of the
//  adder, compares every cycle once armed, and reports pass/fail counts and a sticky error flag.
//  Provides on-chip and in-bench self-checking of adder instances.
// PARAMETERS
//  WIDTH    8   operand/sum width; must equal the adder's WIDTH
//  LATENCY  1   DUT cycles from operand sample to s/c valid (>=1)
//  CNT_W    16  width of the pass/fail counters
// PORTS
//  clk           in   1          rising-edge clock
//  rst           in   1          asynchronous, active-high reset
//  en            in   1          adder enable, as driven to the DUT
//  a, b          in   WIDTH      adder operands, as driven to the DUT
//  cin           in   1          adder carry-in, as driven to the DUT
//  dut_s         in   WIDTH      DUT sum output
//  dut_c         in   1          DUT carry-out
//  clear         in   1          synchronous clear of counters and sticky flag
//  mismatch      out  1          1-cycle pulse on a compare failure
//  err_sticky    out  1          set on first mismatch; held until clear or rst
//  pass_cnt      out  CNT_W      saturating count of passing compares
//  fail_cnt      out  CNT_W      saturating count of failing compares
//  first_fail    out  2*WIDTH+2  {expected c,s, actual c,s} of first failure (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async, rst=1): every output 0, shadow model 0, FSM -> IDLE.
//  - Shadow model mirrors the DUT: on rst exp=0; if en, exp={carry,sum}=a+b+cin, computed
//    WIDTH+1 bits wide with no truncation of carry; otherwise hold. exp is delayed LATENCY-1
//    extra stages, so it aligns with dut_{c,s}.
//  - FSM: IDLE -> ARM on the first cycle with en=1. ARM counts LATENCY cycles, then -> CHECK.
//    CHECK stays until rst. No compare happens in IDLE or ARM.
//  - In CHECK every cycle is a compare, including en=0 hold cycles, where the DUT must hold.
//  - Match: pass_cnt+1. Mismatch: fail_cnt+1, mismatch=1 for that cycle, err_sticky=1.
//  - Registered outputs: mismatch and counters update on the edge after the compared cycle.
//  - Counters saturate at all-ones and never wrap.
//  - clear=1: counters, err_sticky and first_fail go to 0 on that edge. clear wins over a
//    simultaneous compare result. clear does not affect the FSM or the shadow model.
//  - rst mid-run: immediate return to IDLE with all state 0. The DUT also resets to 0, so no
//    false fail occurs. Re-arm waits for the next en=1.
// CONFIGURATION
//  ADDER_CHK_LOG_EN defined: first_fail captures {exp_c,exp_s,dut_c,dut_s} on the first mismatch
//    after reset or clear, and holds it until the next clear or rst.
//  ADDER_CHK_LOG_EN undefined: no capture register is built and first_fail is tied to 0.
// STRUCTURE
//  - Package adder_chk_pkg holds:
//    - the state typedef enum {IDLE, ARM, CHECK}
//    - parameterized result struct {logic c; logic [WIDTH-1:0] s}, or a width function
//    - the counter saturation function
//  - Sub-module adder_ref_model holds the shadow register and the LATENCY delay pipe, and outputs
//    exp_c/exp_s. The top module holds the FSM, compare, counters and log.
// TESTING (WIDTH=8, LATENCY=1)
//  1 rst pulse, then a=8'hFF b=8'h01 cin=1 en=1 with a correct DUT -> exp {1,8'h01};
//    CHECK reached; pass_cnt=1; mismatch=0.
//  2 force dut_s=8'h00 while exp=8'h01 -> mismatch high exactly 1 cycle; fail_cnt=1;
//    err_sticky=1 and held; with the macro, first_fail={1,8'h01,1,8'h00}.
//  3 en=0 for 5 cycles while the DUT holds -> pass_cnt +5. Toggle dut_s during a hold -> fail.
//  4 50 random vectors with rst asserted between edges at vector 40 -> outputs 0 at once;
//    IDLE; no fail after re-arm; fail_cnt=0.
//  5 CNT_W=4, 20 matching cycles -> pass_cnt stays at 4'hF.
//  6 clear=1 in the same cycle as a mismatch -> fail_cnt=0, err_sticky=0, first_fail=0.

Source files
------------

// File: rtl/adder_chk_pkg.sv
// Shared types and helpers for the adder result checker.
package adder_chk_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARM   = 2'd1,
      CHECK = 2'd2
   } chk_state_e;

   // Width of a {carry, sum} result for a given operand width.
   function automatic int res_w(input int width);
      return width + 1;
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_value);
      return (value >= max_value) ? value : value + 32'd1;
   endfunction

endpackage

// File: rtl/adder_ref_model.sv
// Shadow model of the registered adder: one result register plus LATENCY-1 alignment stages.
module adder_ref_model
   import adder_chk_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int LATENCY = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             exp_c,
   output logic [WIDTH-1:0] exp_s
);

   localparam int RW = res_w(WIDTH);

   logic [RW-1:0] shadow;

   // Computed one bit wider than the operands so the carry-out is never lost.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow <= '0;
      end else if (en) begin
         shadow <= RW'(a) + RW'(b) + RW'(cin);
      end
   end

   generate
      if (LATENCY > 1) begin : g_pipe
         logic [RW-1:0] pipe [0:LATENCY-2];

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int i = 0; i < LATENCY - 1; i++) begin
                  pipe[i] <= '0;
               end
            end else begin
               pipe[0] <= shadow;
               for (int i = 1; i < LATENCY - 1; i++) begin
                  pipe[i] <= pipe[i-1];
               end
            end
         end

         assign {exp_c, exp_s} = pipe[LATENCY-2];
      end else begin : g_direct
         assign {exp_c, exp_s} = shadow;
      end
   endgenerate

endmodule

// File: rtl/adder_result_checker.sv
// Response checker for a registered n-bit adder: FSM, compare, saturating counters, sticky flag.
// Define ADDER_CHK_LOG_EN to build the first-failure capture register; otherwise first_fail is 0.
//
//   state | meaning
//   IDLE  | waiting for the first enabled operand sample
//   ARM   | counting LATENCY cycles until the DUT result is valid; no compare
//   CHECK | comparing shadow model against DUT every cycle until rst
module adder_result_checker
   import adder_chk_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int LATENCY = 1,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               cin,
   input  logic [WIDTH-1:0]   dut_s,
   input  logic               dut_c,
   input  logic               clear,
   output logic               mismatch,
   output logic               err_sticky,
   output logic [CNT_W-1:0]   pass_cnt,
   output logic [CNT_W-1:0]   fail_cnt,
   output logic [2*WIDTH+1:0] first_fail
);

   localparam int          ARM_W   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

   chk_state_e       state, state_nxt;
   logic [ARM_W-1:0] arm_cnt, arm_cnt_nxt;
   logic             exp_c;
   logic [WIDTH-1:0] exp_s;
   logic             do_cmp, miss, hit;

   adder_ref_model #(
      .WIDTH   (WIDTH),
      .LATENCY (LATENCY)
   ) u_ref (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .exp_c (exp_c),
      .exp_s (exp_s)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         arm_cnt <= '0;
      end else begin
         state   <= state_nxt;
         arm_cnt <= arm_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      arm_cnt_nxt = arm_cnt;
      case (state)
         IDLE: begin
            if (en) begin
               state_nxt   = ARM;
               arm_cnt_nxt = ARM_W'(LATENCY - 1);
            end
         end
         ARM: begin
            if (arm_cnt == '0) begin
               state_nxt = CHECK;
            end else begin
               arm_cnt_nxt = arm_cnt - 1'b1;
            end
         end
         CHECK:   state_nxt = CHECK;
         default: state_nxt = IDLE;
      endcase
   end

   // Hold cycles are compared too: the DUT must keep its last result while en=0.
   assign do_cmp = (state == CHECK);
   assign miss   = do_cmp && ({exp_c, exp_s} != {dut_c, dut_s});
   assign hit    = do_cmp && !miss;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mismatch   <= 1'b0;
         err_sticky <= 1'b0;
         pass_cnt   <= '0;
         fail_cnt   <= '0;
      end else if (clear) begin
         mismatch   <= 1'b0;
         err_sticky <= 1'b0;
         pass_cnt   <= '0;
         fail_cnt   <= '0;
      end else begin
         mismatch <= miss;
         if (hit) begin
            pass_cnt <= CNT_W'(sat_inc(32'(pass_cnt), CNT_MAX));
         end
         if (miss) begin
            fail_cnt   <= CNT_W'(sat_inc(32'(fail_cnt), CNT_MAX));
            err_sticky <= 1'b1;
         end
      end
   end

`ifdef ADDER_CHK_LOG_EN
   logic [2*WIDTH+1:0] log_q;

   // err_sticky low means no failure has been seen since rst or clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         log_q <= '0;
      end else if (clear) begin
         log_q <= '0;
      end else if (miss && !err_sticky) begin
         log_q <= {exp_c, exp_s, dut_c, dut_s};
      end
   end

   assign first_fail = log_q;
`else
   assign first_fail = '0;
`endif

endmodule

// File: tb/tb_adder_result_checker.sv
// Bench for adder_result_checker: behavioural adder with fault injection, scoreboard of expected outputs.
module tb_adder_result_checker;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst, en, cin, clear;
   logic [W-1:0] a, b, flip;
   logic         add_c;
   logic [W-1:0] add_s;
   logic [W-1:0] dut_s;
   logic         dut_c;

   logic           mismatch, err_sticky;
   logic [15:0]    pass_cnt, fail_cnt;
   logic [2*W+1:0] first_fail;
   logic           mismatch4, sticky4;
   logic [3:0]     pass4, fail4;
   logic [2*W+1:0] ff4;

   typedef struct {
      logic           mm;
      int             pass;
      int             fail;
      logic           sticky;
      logic [2*W+1:0] ff;
   } exp_t;

   exp_t           sb[$];
   int             m_pass, m_fail, phase;
   logic           m_sticky;
   logic [2*W+1:0] m_ff;
   int             n_total = 0;
   int             n_pass  = 0;

   always #5 clk = ~clk;

   // Correct registered adder; flip corrupts its sum to model a faulty DUT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) {add_c, add_s} <= '0;
      else if (en) {add_c, add_s} <= {1'b0, a} + {1'b0, b} + {8'b0, cin};
   end
   assign dut_s = add_s ^ flip;
   assign dut_c = add_c;

   adder_result_checker #(.WIDTH(W), .LATENCY(1), .CNT_W(16)) u_dut (
      .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .cin(cin),
      .dut_s(dut_s), .dut_c(dut_c), .clear(clear),
      .mismatch(mismatch), .err_sticky(err_sticky),
      .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .first_fail(first_fail)
   );

   adder_result_checker #(.WIDTH(W), .LATENCY(1), .CNT_W(4)) u_sat (
      .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .cin(cin),
      .dut_s(dut_s), .dut_c(dut_c), .clear(clear),
      .mismatch(mismatch4), .err_sticky(sticky4),
      .pass_cnt(pass4), .fail_cnt(fail4), .first_fail(ff4)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_total++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: got %0h, want %0h", tag, obs, expv);
   endtask

   function automatic int sat(input int v, input int max_v);
      return (v > max_v) ? max_v : v;
   endfunction

   task automatic model_reset();
      m_pass   = 0;
      m_fail   = 0;
      m_sticky = 1'b0;
      m_ff     = '0;
      phase    = 0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_mismatch"}, 32'(mismatch), 0);
      chk({tag, "_sticky"},   32'(err_sticky), 0);
      chk({tag, "_pass"},     32'(pass_cnt), 0);
      chk({tag, "_fail"},     32'(fail_cnt), 0);
      chk({tag, "_ff"},       32'(first_fail), 0);
      chk({tag, "_pass4"},    32'(pass4), 0);
      chk({tag, "_fail4"},    32'(fail4), 0);
      chk({tag, "_ff4"},      32'(ff4), 0);
   endtask

   // One clock: drive at negedge, push the expected outcome, pop and compare after the edge.
   task automatic cycle(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vcin,
                        input logic ven, input logic [W-1:0] vflip, input logic vclr);
      exp_t e;
      logic cmp, bad;
      @(negedge clk);
      a = va; b = vb; cin = vcin; en = ven; flip = vflip; clear = vclr;
      cmp = (phase == 2);
      bad = cmp && (vflip != '0);
      if (vclr) begin
         m_pass = 0; m_fail = 0; m_sticky = 1'b0; m_ff = '0;
         e.mm = 1'b0;
      end else begin
         e.mm = bad;
         if (cmp && !bad) m_pass = sat(m_pass + 1, 65535);
         if (bad) begin
`ifdef ADDER_CHK_LOG_EN
            if (!m_sticky) m_ff = {add_c, add_s, add_c, add_s ^ vflip};
`endif
            m_fail   = sat(m_fail + 1, 65535);
            m_sticky = 1'b1;
         end
      end
      e.pass = m_pass; e.fail = m_fail; e.sticky = m_sticky; e.ff = m_ff;
      sb.push_back(e);
      if (phase == 0 && ven) phase = 1;
      else if (phase == 1) phase = 2;
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("mismatch",   32'(mismatch),   32'(e.mm));
      chk("pass_cnt",   32'(pass_cnt),   32'(e.pass));
      chk("fail_cnt",   32'(fail_cnt),   32'(e.fail));
      chk("err_sticky", 32'(err_sticky), 32'(e.sticky));
      chk("first_fail", 32'(first_fail), 32'(e.ff));
      chk("pass4_sat",  32'(pass4),      32'(sat(e.pass, 15)));
      chk("fail4_sat",  32'(fail4),      32'(sat(e.fail, 15)));
      chk("sticky4",    32'(sticky4),    32'(e.sticky));
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; cin = 1'b0; clear = 1'b0;
      a = '0; b = '0; flip = '0;
      model_reset();
      #12;
      chk_all_zero("reset");
      @(negedge clk);
      rst = 1'b0;

      // Carry-out case FF+01+1 = {1,01}: arm, then first compare passes.
      cycle(8'hFF, 8'h01, 1'b1, 1'b1, 8'h00, 1'b0);
      cycle(8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
      cycle(8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
      chk("t1_pass_is_1", 32'(pass_cnt), 1);

      // Sum forced to 00 while 01 expected.
      cycle(8'h00, 8'h00, 1'b0, 1'b0, 8'h01, 1'b0);
      chk("t2_dut_s_zero", 32'(dut_s), 0);
      cycle(8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
      chk("t2_sticky_held", 32'(err_sticky), 1);

      // Hold cycles, then a toggle during hold.
      for (int i = 0; i < 5; i++) cycle(8'($urandom_range(0, 255)), 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
      chk("t3_pass_7", 32'(pass_cnt), 7);
      cycle(8'h00, 8'h00, 1'b0, 1'b0, 8'h80, 1'b0);
      chk("t3_fail_2", 32'(fail_cnt), 2);

      // Random vectors with an asynchronous reset between edges at vector 40.
      for (int i = 0; i < 50; i++) begin
         if (i == 40) begin
            #1 rst = 1'b1;
            #1 chk_all_zero("midrun_rst");
            model_reset();
            #1 rst = 1'b0;
         end
         cycle(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 8'h00, 1'b0);
      end
      for (int i = 0; i < 3; i++)
         cycle(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b1, 1'b1, 8'h00, 1'b0);
      chk("t4_fail_zero", 32'(fail_cnt), 0);

      // Clear coincident with a mismatch.
      cycle(8'h12, 8'h34, 1'b0, 1'b1, 8'h01, 1'b1);
      chk("t6_fail_clr", 32'(fail_cnt), 0);
      chk("t6_sticky_clr", 32'(err_sticky), 0);
      chk("t6_ff_clr", 32'(first_fail), 0);

      // Matching cycles past the 4-bit counter's saturation point.
      for (int i = 0; i < 20; i++)
         cycle(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 8'h00, 1'b0);
      chk("t5_pass_20", 32'(pass_cnt), 20);
      chk("t5_pass4_sat", 32'(pass4), 32'h0000_000F);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
